// File: rtl/divider_pkg.sv
// Shared types and helpers for the parametrised restoring divider.
package divider_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ITER,
    FIX,
    DONE
  } state_t;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DIV_LAT_NORM  = DEFAULT_WIDTH + 3;
  localparam int DIV_LAT_EXC   = 2;

  // Normal-path latency for an arbitrary width (ctrl_DIV edge to resultRDY edge).
  function automatic int div_lat_norm(input int width);
    return width + 3;
  endfunction

  // Magnitude of a value held in the low bits of x; the caller truncates to its width.
  function automatic logic [63:0] abs_val(input logic [63:0] x, input logic neg);
    return neg ? (~x + 64'd1) : x;
  endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring-division step: shift {r,q} left, trial-subtract d, restore on borrow.
module divider_step
  import divider_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0]   r_sh;
  logic [WIDTH+1:0] diff;
  logic             borrow;
  logic             unused_diff_msb;

  assign r_sh   = {r, q[WIDTH-1]};
  assign diff   = {1'b0, r_sh} - {2'b00, d};
  assign borrow = diff[WIDTH+1];

  // r < d on entry, so a successful subtraction always fits in WIDTH bits.
  assign unused_diff_msb = diff[WIDTH];

  assign r_next = borrow ? r_sh[WIDTH-1:0] : diff[WIDTH-1:0];
  assign q_next = {q[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/divider_param.sv
// Iterative radix-2 restoring divider with signed mode, exceptions and restart on ctrl_DIV.
// Define DIVIDER_REMAINDER_EN to add the data_remainder output.
module divider_param
  import divider_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 2)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic             ctrl_signed,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy,
  output logic [CNT_W-1:0] counter
`ifdef DIVIDER_REMAINDER_EN
  ,
  output logic [WIDTH-1:0] data_remainder
`endif
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, r_reg, q_reg, d_reg;
  logic [WIDTH-1:0] r_step, q_step, a_abs, b_abs;
  logic [CNT_W-1:0] cnt_reg;
  logic             sgn_reg, exc_pend;
  logic             neg_a, neg_b, div_zero, sgn_ovf;

  assign neg_a    = sgn_reg & a_reg[WIDTH-1];
  assign neg_b    = sgn_reg & b_reg[WIDTH-1];
  assign div_zero = (b_reg == '0);
  assign sgn_ovf  = sgn_reg && (a_reg == MIN_VAL) && (b_reg == '1);
  assign a_abs    = WIDTH'(abs_val(64'(a_reg), neg_a));
  assign b_abs    = WIDTH'(abs_val(64'(b_reg), neg_b));
  assign busy     = (state != IDLE);
  assign counter  = cnt_reg;

  divider_step #(.WIDTH(WIDTH)) u_step (
    .r      (r_reg),
    .q      (q_reg),
    .d      (d_reg),
    .r_next (r_step),
    .q_next (q_step)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A new ctrl_DIV always wins: it aborts whatever is in flight and restarts.
  always_comb begin
    state_next = state;
    if (ctrl_DIV) begin
      state_next = CHECK;
    end else begin
      case (state)
        IDLE:    state_next = IDLE;
        CHECK:   state_next = (div_zero || sgn_ovf) ? DONE : ITER;
        ITER:    state_next = (cnt_reg == CNT_W'(WIDTH - 1)) ? FIX : ITER;
        FIX:     state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_reg          <= '0;
      b_reg          <= '0;
      sgn_reg        <= 1'b0;
      r_reg          <= '0;
      q_reg          <= '0;
      d_reg          <= '0;
      cnt_reg        <= '0;
      exc_pend       <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
`ifdef DIVIDER_REMAINDER_EN
      data_remainder <= '0;
`endif
    end else begin
      data_resultRDY <= 1'b0;
      // The finishing operation still reports even if a new one starts on this edge.
      if (state == DONE) begin
        data_result    <= q_reg;
        data_exception <= exc_pend;
        data_resultRDY <= 1'b1;
`ifdef DIVIDER_REMAINDER_EN
        data_remainder <= r_reg;
`endif
      end
      if (ctrl_DIV) begin
        a_reg   <= data_operandA;
        b_reg   <= data_operandB;
        sgn_reg <= ctrl_signed;
        if (state != DONE) data_exception <= 1'b0;
      end else begin
        case (state)
          CHECK: begin
            cnt_reg <= '0;
            if (div_zero) begin
              q_reg    <= '0;
              r_reg    <= a_reg;
              exc_pend <= 1'b1;
            end else if (sgn_ovf) begin
              q_reg    <= MIN_VAL;
              r_reg    <= a_reg;
              exc_pend <= 1'b1;
            end else begin
              q_reg    <= a_abs;
              r_reg    <= '0;
              d_reg    <= b_abs;
              exc_pend <= 1'b0;
            end
          end
          ITER: begin
            r_reg   <= r_step;
            q_reg   <= q_step;
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
          FIX: begin
            if (neg_a ^ neg_b) q_reg <= -q_reg;
`ifdef DIVIDER_REMAINDER_EN
            if (neg_a) r_reg <= -r_reg;
`endif
          end
          default: ;
        endcase
      end
    end
  end

endmodule
